// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light lamp interface.
//   phase_t     : decoded phase (SYNC while the lamps are not yet understood)
//   LAMP_*      : legal {red,green,yellow} drive patterns
//   next_phase  : legal successor of a phase in the normal light cycle
package traffic_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    RED    = 2'd3
  } phase_t;

  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b001;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  // GREEN -> YELLOW -> RED -> GREEN. SYNC has no successor; it maps to itself.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      RED:     return GREEN;
      default: return SYNC;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for phase dwell measurement.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force count to 0 (highest priority)
//   load1      : force count to 1 (start of a new phase)
//   inc        : increment, holding at the all-ones maximum
//   count      : current count
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load1) begin
      count <= CNT_W'(1);
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// In-system checker for the traffic-light lamp interface. Decodes the three
// lamp drives into a phase, measures phase dwell, and raises sticky flags on
// illegal patterns, illegal phase order, short dwell and over-long yellow.
//   clk, rst_n    : clock, asynchronous active-low reset
//   red/green/yellow : lamp drives, synchronous to clk
//   clr_err       : synchronous clear of all sticky error flags
//   phase         : decoded phase (0 SYNC, 1 GREEN, 2 YELLOW, 3 RED)
//   dwell         : cycles spent in the current phase (saturating)
//   phase_change  : one-cycle pulse on entry into GREEN, YELLOW or RED
//   err_onehot/err_order/err_short/err_long : sticky error flags
//   err_any       : registered OR of the four flags (one cycle behind them)
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 1,
  parameter int MIN_YELLOW = 1,
  parameter int MIN_RED    = 1,
  parameter int MAX_YELLOW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             red,
  input  logic             green,
  input  logic             yellow,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic             phase_change,
  output logic             err_onehot,
  output logic             err_order,
  output logic             err_short,
  output logic             err_long,
  output logic             err_any
);

  localparam logic [CNT_W-1:0] MAX_Y_C = CNT_W'(MAX_YELLOW);

  function automatic logic [CNT_W-1:0] min_dwell(input phase_t p);
    case (p)
      GREEN:   return CNT_W'(MIN_GREEN);
      YELLOW:  return CNT_W'(MIN_YELLOW);
      RED:     return CNT_W'(MIN_RED);
      default: return '0;
    endcase
  endfunction

  phase_t state_q, state_n;
  phase_t lamp_phase;
  logic   lamp_valid;
  logic   cnt_clr, cnt_load, cnt_inc, enter;
  logic   ev_onehot, ev_order, ev_short, ev_long;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lamp_valid = 1'b1;
    lamp_phase = SYNC;
    case ({red, green, yellow})
      LAMP_GREEN:  lamp_phase = GREEN;
      LAMP_YELLOW: lamp_phase = YELLOW;
      LAMP_RED:    lamp_phase = RED;
      default:     lamp_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_n   = state_q;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    enter     = 1'b0;
    ev_onehot = 1'b0;
    ev_order  = 1'b0;
    ev_short  = 1'b0;
    ev_long   = 1'b0;
    if (state_q == SYNC) begin
      // Invalid patterns here are start-up noise, not errors.
      if (lamp_valid) begin
        state_n  = lamp_phase;
        cnt_load = 1'b1;
        enter    = 1'b1;
      end
    end else if (!lamp_valid) begin
      ev_onehot = 1'b1;
      state_n   = SYNC;
      cnt_clr   = 1'b1;
    end else if (lamp_phase == state_q) begin
      cnt_inc = 1'b1;
      // Fires on the edge where dwell would reach MAX_YELLOW+1.
      if ((state_q == YELLOW) && (dwell == MAX_Y_C)) ev_long = 1'b1;
    end else begin
      // Follow the observed phase even when the transition is illegal.
      state_n  = lamp_phase;
      cnt_load = 1'b1;
      enter    = 1'b1;
      ev_order = (lamp_phase != next_phase(state_q));
      ev_short = (dwell < min_dwell(state_q));
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .load1 (cnt_load),
    .inc   (cnt_inc),
    .count (dwell)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SYNC;
      phase_change <= 1'b0;
      err_onehot   <= 1'b0;
      err_order    <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_any      <= 1'b0;
    end else begin
      state_q      <= state_n;
      phase_change <= enter;
      // A new event wins over a simultaneous clear.
      err_onehot   <= (err_onehot & ~clr_err) | ev_onehot;
      err_order    <= (err_order  & ~clr_err) | ev_order;
      err_short    <= (err_short  & ~clr_err) | ev_short;
      err_long     <= (err_long   & ~clr_err) | ev_long;
      err_any      <= err_onehot | err_order | err_short | err_long;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Directed bench for traffic_lamp_monitor. u_dut uses default parameters;
// u_dut_s uses MIN_RED=2 for the short-dwell scenario. Both share the inputs.
module tb_traffic_lamp_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] lamps = 3'b000;
  logic       clr_err = 1'b0;

  logic [1:0] phase, s_phase;
  logic [7:0] dwell, s_dwell;
  logic       phase_change, s_phase_change;
  logic       err_onehot, err_order, err_short, err_long, err_any;
  logic       s_err_onehot, s_err_order, s_err_short, s_err_long, s_err_any;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_lamp_monitor u_dut (
    .clk(clk), .rst_n(rst_n),
    .red(lamps[2]), .green(lamps[1]), .yellow(lamps[0]),
    .clr_err(clr_err),
    .phase(phase), .dwell(dwell), .phase_change(phase_change),
    .err_onehot(err_onehot), .err_order(err_order), .err_short(err_short),
    .err_long(err_long), .err_any(err_any)
  );

  traffic_lamp_monitor #(.MIN_RED(2)) u_dut_s (
    .clk(clk), .rst_n(rst_n),
    .red(lamps[2]), .green(lamps[1]), .yellow(lamps[0]),
    .clr_err(clr_err),
    .phase(s_phase), .dwell(s_dwell), .phase_change(s_phase_change),
    .err_onehot(s_err_onehot), .err_order(s_err_order), .err_short(s_err_short),
    .err_long(s_err_long), .err_any(s_err_any)
  );

  // Drive a pattern for one edge, then sample 1 time unit after that edge.
  task automatic step(input logic [2:0] p);
    lamps = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    lamps   = 3'b000;
    clr_err = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] errs_main();
    return {err_onehot, err_order, err_short, err_long, err_any};
  endfunction

  task automatic test_reset();
    do_reset();
    total++;
    if ({phase, dwell, phase_change} !== {2'd0, 8'd0, 1'b0} || errs_main() !== 5'b0) begin
      bad++;
      $display("FAIL reset_state got phase=%0d dwell=%0d pc=%0b errs=%05b exp 0/0/0/00000",
               phase, dwell, phase_change, errs_main());
    end
    for (int i = 0; i < 5; i++) begin
      step(3'b000);
      total++;
      if (phase !== 2'd0 || dwell !== 8'd0 || errs_main() !== 5'b0) begin
        bad++;
        $display("FAIL sync_idle[%0d] got phase=%0d dwell=%0d errs=%05b exp 0/0/00000",
                 i, phase, dwell, errs_main());
      end
    end
    step(3'b010);
    total++;
    if (phase !== 2'd1 || dwell !== 8'd1 || phase_change !== 1'b1) begin
      bad++;
      $display("FAIL sync_exit got phase=%0d dwell=%0d pc=%0b exp 1/1/1", phase, dwell, phase_change);
    end
    step(3'b010);
    total++;
    if (phase_change !== 1'b0 || dwell !== 8'd2) begin
      bad++;
      $display("FAIL pulse_once got pc=%0b dwell=%0d exp 0/2", phase_change, dwell);
    end
  endtask

  task automatic test_legal_cycle();
    logic [2:0] pat [6] = '{3'b010, 3'b001, 3'b001, 3'b001, 3'b100, 3'b010};
    logic [1:0] exp_ph [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd1};
    logic [7:0] exp_dw [6] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd1, 8'd1};
    logic       exp_pc [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(pat[i]);
      total++;
      if (phase !== exp_ph[i] || dwell !== exp_dw[i] || phase_change !== exp_pc[i]) begin
        bad++;
        $display("FAIL legal[%0d] got phase=%0d dwell=%0d pc=%0b exp %0d/%0d/%0b",
                 i, phase, dwell, phase_change, exp_ph[i], exp_dw[i], exp_pc[i]);
      end
    end
    step(3'b010);
    total++;
    if (errs_main() !== 5'b0) begin
      bad++;
      $display("FAIL legal_errs got errs=%05b exp 00000", errs_main());
    end
  endtask

  task automatic test_order();
    do_reset();
    step(3'b010);
    step(3'b100);
    total++;
    if (err_order !== 1'b1 || phase !== 2'd3 || err_any !== 1'b0 || err_short !== 1'b0) begin
      bad++;
      $display("FAIL order_set got order=%0b phase=%0d any=%0b short=%0b exp 1/3/0/0",
               err_order, phase, err_any, err_short);
    end
    step(3'b100);
    total++;
    if (err_any !== 1'b1 || dwell !== 8'd2) begin
      bad++;
      $display("FAIL order_any got any=%0b dwell=%0d exp 1/2", err_any, dwell);
    end
    clr_err = 1'b1;
    step(3'b100);
    clr_err = 1'b0;
    total++;
    if (err_order !== 1'b0) begin
      bad++;
      $display("FAIL order_clr got order=%0b exp 0", err_order);
    end
    step(3'b100);
    total++;
    if (errs_main() !== 5'b0) begin
      bad++;
      $display("FAIL order_any_clr got errs=%05b exp 00000", errs_main());
    end
  endtask

  task automatic test_onehot();
    do_reset();
    step(3'b010);
    step(3'b001);
    step(3'b110);
    total++;
    if (err_onehot !== 1'b1 || phase !== 2'd0 || dwell !== 8'd0 || phase_change !== 1'b0) begin
      bad++;
      $display("FAIL onehot_set got oh=%0b phase=%0d dwell=%0d pc=%0b exp 1/0/0/0",
               err_onehot, phase, dwell, phase_change);
    end
    step(3'b001);
    total++;
    if (phase !== 2'd2 || dwell !== 8'd1 || phase_change !== 1'b1 || err_order !== 1'b0 || err_short !== 1'b0) begin
      bad++;
      $display("FAIL onehot_reenter got phase=%0d dwell=%0d pc=%0b order=%0b short=%0b exp 2/1/1/0/0",
               phase, dwell, phase_change, err_order, err_short);
    end
  endtask

  task automatic test_long();
    do_reset();
    step(3'b010);
    for (int k = 1; k <= 16; k++) begin
      step(3'b001);
      total++;
      if (err_long !== 1'b0 || dwell !== 8'(k)) begin
        bad++;
        $display("FAIL long_early[%0d] got long=%0b dwell=%0d exp 0/%0d", k, err_long, dwell, k);
      end
    end
    step(3'b001);
    total++;
    if (err_long !== 1'b1 || dwell !== 8'd17) begin
      bad++;
      $display("FAIL long_set got long=%0b dwell=%0d exp 1/17", err_long, dwell);
    end
    step(3'b001);
    total++;
    if (err_long !== 1'b1 || dwell !== 8'd18 || err_any !== 1'b1) begin
      bad++;
      $display("FAIL long_hold got long=%0b dwell=%0d any=%0b exp 1/18/1", err_long, dwell, err_any);
    end
  endtask

  task automatic test_short();
    do_reset();
    step(3'b010);
    step(3'b010);
    step(3'b001);
    step(3'b100);
    step(3'b010);
    total++;
    if (s_err_short !== 1'b1 || s_err_order !== 1'b0 || err_short !== 1'b0) begin
      bad++;
      $display("FAIL short_set got s_short=%0b s_order=%0b default_short=%0b exp 1/0/0",
               s_err_short, s_err_order, err_short);
    end
    // Clear on the same edge as another short red exit: flag must stay set.
    step(3'b001);
    step(3'b100);
    clr_err = 1'b1;
    step(3'b010);
    total++;
    if (s_err_short !== 1'b1) begin
      bad++;
      $display("FAIL short_clr_collide got s_short=%0b exp 1", s_err_short);
    end
    step(3'b010);
    clr_err = 1'b0;
    total++;
    if (s_err_short !== 1'b0) begin
      bad++;
      $display("FAIL short_clr got s_short=%0b exp 0", s_err_short);
    end
    // Red for one cycle then yellow: short and order on the same edge.
    step(3'b001);
    step(3'b100);
    step(3'b001);
    total++;
    if (s_err_short !== 1'b1 || s_err_order !== 1'b1) begin
      bad++;
      $display("FAIL short_and_order got s_short=%0b s_order=%0b exp 1/1", s_err_short, s_err_order);
    end
  endtask

  task automatic test_saturate();
    int pulses = 0;
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      step(3'b010);
      if (phase_change) pulses++;
      if (i == 254 || i == 255 || i == 300) begin
        total++;
        if (dwell !== ((i < 255) ? 8'(i) : 8'd255)) begin
          bad++;
          $display("FAIL saturate[%0d] got dwell=%0d exp %0d", i, dwell, (i < 255) ? i : 255);
        end
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL steady_green_pulses got %0d exp 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(3'b010);
    step(3'b010);
    step(3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (phase !== 2'd0 || dwell !== 8'd0 || phase_change !== 1'b0) begin
      bad++;
      $display("FAIL reset_async got phase=%0d dwell=%0d pc=%0b exp 0/0/0", phase, dwell, phase_change);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3'b010);
    total++;
    if (phase !== 2'd1 || dwell !== 8'd1 || phase_change !== 1'b1) begin
      bad++;
      $display("FAIL reset_restart got phase=%0d dwell=%0d pc=%0b exp 1/1/1", phase, dwell, phase_change);
    end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_order();
    test_onehot();
    test_long();
    test_short();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
